// File: rtl/wf_fetch_rr_scheduler_pkg.sv
// Shared constants and types for the wavefront fetch scheduler.
package wf_fetch_rr_scheduler_pkg;

  localparam int NUM_WF  = 40;
  localparam int WFID_W  = 6;
  localparam int WF_LAST = NUM_WF - 1;

  typedef logic [WFID_W-1:0] wfid_t;

  // IDLE: searching for an eligible wavefront; OFFER: grant held until ack
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/wf_rr_pick.sv
// Round-robin picker: first eligible wavefront at or after last_ptr+1, wrapping at NUM_WF.
module wf_rr_pick #(
  parameter int NUM_WF = 40,
  parameter int WFID_W = 6
) (
  input  logic [NUM_WF-1:0] eligible,
  input  logic [WFID_W-1:0] last_ptr,
  output logic              any_eligible,
  output logic [WFID_W-1:0] pick_wfid
);

  localparam logic [WFID_W:0] NWF = (WFID_W+1)'(NUM_WF);

  logic [WFID_W:0]   start_sum;
  logic [WFID_W:0]   start;
  logic [NUM_WF-1:0] rot;
  logic [WFID_W-1:0] offset;
  logic [WFID_W:0]   pick_sum;

  // Search start: last_ptr+1 with one conditional subtract so it never leaves 0..NUM_WF-1
  always_comb begin
    start_sum = {1'b0, last_ptr} + (WFID_W+1)'(1);
    start     = (start_sum >= NWF) ? (start_sum - NWF) : start_sum;
  end

  // Rotate eligibility so bit 0 is the start index; indices >= NUM_WF are never formed
  always_comb begin
    logic [WFID_W:0] idx;
    rot = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      idx = start + (WFID_W+1)'(i);
      if (idx >= NWF) idx = idx - NWF;
      rot[i] = eligible[WFID_W'(idx)];
    end
  end

  // Lowest set bit of the rotated vector is the round-robin winner
  always_comb begin
    any_eligible = 1'b0;
    offset       = '0;
    for (int i = NUM_WF - 1; i >= 0; i--) begin
      if (rot[i]) begin
        any_eligible = 1'b1;
        offset       = WFID_W'(i);
      end
    end
  end

  // Undo the rotation, again modulo NUM_WF
  always_comb begin
    pick_sum  = start + {1'b0, offset};
    pick_wfid = (pick_sum >= NWF) ? WFID_W'(pick_sum - NWF) : WFID_W'(pick_sum);
  end

endmodule

// File: rtl/wf_fetch_rr_scheduler.sv
// Wavefront fetch scheduler: round-robin grant with valid/ack and per-wavefront in-flight masking.
module wf_fetch_rr_scheduler #(
  parameter int NUM_WF = wf_fetch_rr_scheduler_pkg::NUM_WF,
  parameter int WFID_W = wf_fetch_rr_scheduler_pkg::WFID_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_WF-1:0] fetch_ready,
  input  logic              grant_ack,
  input  logic              fetch_done_valid,
  input  logic [WFID_W-1:0] fetch_done_wfid,
  output logic              grant_valid,
  output logic [WFID_W-1:0] grant_wfid,
  output logic [NUM_WF-1:0] outstanding
);

  import wf_fetch_rr_scheduler_pkg::fetch_state_e;
  import wf_fetch_rr_scheduler_pkg::ST_IDLE;
  import wf_fetch_rr_scheduler_pkg::ST_OFFER;

  localparam logic [WFID_W-1:0] LAST_ID = WFID_W'(NUM_WF - 1);

  fetch_state_e      state, state_nxt;
  logic [WFID_W-1:0] last_ptr, last_ptr_nxt;
  logic              grant_valid_nxt;
  logic [WFID_W-1:0] grant_wfid_nxt;
  logic [NUM_WF-1:0] eligible;
  logic [NUM_WF-1:0] set_mask, clr_mask;
  logic              any_eligible;
  logic [WFID_W-1:0] pick_wfid;

  // Registered outstanding only: a done-clear reaches eligibility a cycle later
  assign eligible = fetch_ready & ~outstanding;

  wf_rr_pick #(
    .NUM_WF (NUM_WF),
    .WFID_W (WFID_W)
  ) u_pick (
    .eligible     (eligible),
    .last_ptr     (last_ptr),
    .any_eligible (any_eligible),
    .pick_wfid    (pick_wfid)
  );

  // Next state: pick in IDLE, hold the committed grant in OFFER until ack
  always_comb begin
    state_nxt       = state;
    grant_valid_nxt = grant_valid;
    grant_wfid_nxt  = grant_wfid;
    last_ptr_nxt    = last_ptr;
    set_mask        = '0;
    case (state)
      ST_IDLE: begin
        if (any_eligible) begin
          state_nxt       = ST_OFFER;
          grant_valid_nxt = 1'b1;
          grant_wfid_nxt  = pick_wfid;
        end
      end
      ST_OFFER: begin
        if (grant_ack) begin
          state_nxt              = ST_IDLE;
          grant_valid_nxt        = 1'b0;
          last_ptr_nxt           = grant_wfid;
          set_mask[grant_wfid]   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Fetch return clears its in-flight flag; out-of-range ids are dropped
  always_comb begin
    clr_mask = '0;
    if (fetch_done_valid && (fetch_done_wfid <= LAST_ID)) clr_mask[fetch_done_wfid] = 1'b1;
  end

  // State, grant and pointer registers; set wins so a stray done never cancels a fresh grant
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant_valid <= 1'b0;
      grant_wfid  <= '0;
      last_ptr    <= LAST_ID;
      outstanding <= '0;
    end else begin
      state       <= state_nxt;
      grant_valid <= grant_valid_nxt;
      grant_wfid  <= grant_wfid_nxt;
      last_ptr    <= last_ptr_nxt;
      outstanding <= (outstanding & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: tb/tb_wf_fetch_rr_scheduler.sv
// Bench for wf_fetch_rr_scheduler: directed scenarios plus random traffic against a queue scoreboard.
module tb_wf_fetch_rr_scheduler;

  localparam int NWF = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [39:0] fetch_ready = '0;
  logic        grant_ack = 1'b0;
  logic        fetch_done_valid = 1'b0;
  logic [5:0]  fetch_done_wfid = '0;
  logic        grant_valid;
  logic [5:0]  grant_wfid;
  logic [39:0] outstanding;

  int checks = 0;
  int errors = 0;

  wf_fetch_rr_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_ready      (fetch_ready),
    .grant_ack        (grant_ack),
    .fetch_done_valid (fetch_done_valid),
    .fetch_done_wfid  (fetch_done_wfid),
    .grant_valid      (grant_valid),
    .grant_wfid       (grant_wfid),
    .outstanding      (outstanding)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-cycle behaviour stated directly from the rules
  bit          m_gv = 0;
  int          m_gw = 0;
  int          m_last = NWF - 1;
  bit [39:0]   m_outs = '0;
  bit          q_gv[$];
  int          q_gw[$];
  bit [39:0]   q_outs[$];
  int          gseq[$];
  bit          prev_gv = 0;

  always @(posedge clk) begin : model
    bit        was_offer;
    bit [39:0] old_outs;
    int        idx;
    if (rst) begin
      m_gv = 0; m_gw = 0; m_last = NWF - 1; m_outs = '0;
    end else begin
      was_offer = m_gv;
      old_outs  = m_outs;
      if (fetch_done_valid && fetch_done_wfid < NWF) m_outs[fetch_done_wfid] = 1'b0;
      if (m_gv && grant_ack) begin
        m_outs[m_gw] = 1'b1;
        m_last = m_gw;
        m_gv = 0;
      end
      if (!was_offer) begin
        for (int k = 1; k <= NWF; k++) begin
          idx = (m_last + k) % NWF;
          if (!m_gv && fetch_ready[idx] && !old_outs[idx]) begin
            m_gv = 1;
            m_gw = idx;
          end
        end
      end
    end
    q_gv.push_back(m_gv);
    q_gw.push_back(m_gw);
    q_outs.push_back(m_outs);
  end

  // Monitor: compare the DUT against the oldest expectation once per cycle
  always @(negedge clk) begin : monitor
    bit        e_gv;
    int        e_gw;
    bit [39:0] e_outs;
    if (q_gv.size() > 0) begin
      e_gv = q_gv.pop_front();
      e_gw = q_gw.pop_front();
      e_outs = q_outs.pop_front();
      chk("sb_grant_valid", 64'(grant_valid), 64'(e_gv));
      chk("sb_grant_wfid", 64'(grant_wfid), 64'(e_gw));
      chk("sb_outstanding", 64'(outstanding), 64'(e_outs));
    end
    if (grant_valid && !prev_gv) gseq.push_back(int'(grant_wfid));
    prev_gv = grant_valid;
  end

  task automatic cyc(input logic a, input logic dv, input logic [5:0] dw);
    grant_ack = a;
    fetch_done_valid = dv;
    fetch_done_wfid = dw;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int        pend_due[$];
    int        pend_wf[$];
    logic      dv;
    logic [5:0] dw;
    logic [63:0] r;
    int        cand[$];

    rst = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    rst = 1'b0;

    // All wavefronts ready, ack immediately, done 3 cycles after ack: 0..39 then 0
    fetch_ready = '1;
    gseq.delete();
    for (int c = 0; c < 90; c++) begin
      dv = 0; dw = '0;
      if (pend_due.size() > 0 && pend_due[0] == c) begin
        void'(pend_due.pop_front());
        dv = 1; dw = 6'(pend_wf.pop_front());
      end
      if (grant_valid) begin
        pend_due.push_back(c + 3);
        pend_wf.push_back(int'(grant_wfid));
      end
      cyc(grant_valid, dv, dw);
    end
    fetch_ready = '0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("p1_grant_count", 64'(gseq.size() >= 41), 64'(1));
    for (int i = 0; i < 41; i++) chk("p1_seq", 64'(gseq[i]), 64'(i % NWF));

    // last_ptr=38, then ready {2,39}: 39 first, then 2
    do_reset();
    fetch_ready = 40'(1) << 38;
    gseq.delete();
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    fetch_ready = (40'(1) << 2) | (40'(1) << 39);
    for (int c = 0; c < 8; c++) cyc(grant_valid, c == 3, 6'd39);
    fetch_ready = '0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("p2_first", 64'(gseq[0]), 64'(38));
    chk("p2_second", 64'(gseq[1]), 64'(39));
    chk("p2_third", 64'(gseq[2]), 64'(2));

    // Outstanding masks the only ready wavefront until its done
    do_reset();
    fetch_ready = 40'(1) << 5;
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (4) cyc(0, 0, 0);
    chk("p3_masked_gv", 64'(grant_valid), 64'(0));
    chk("p3_out5", 64'(outstanding[5]), 64'(1));
    cyc(0, 1, 6'd5);
    cyc(0, 0, 0);
    chk("p3_reoffer_gv", 64'(grant_valid), 64'(1));
    chk("p3_reoffer_wf", 64'(grant_wfid), 64'(5));
    cyc(1, 0, 0);
    fetch_ready = '0;

    // Committed grant held while ack is low and ready drops
    do_reset();
    fetch_ready = 40'(1) << 7;
    cyc(0, 0, 0);
    fetch_ready = '0;
    for (int c = 0; c < 4; c++) begin
      cyc(0, 0, 0);
      chk("p4_hold_gv", 64'(grant_valid), 64'(1));
      chk("p4_hold_wf", 64'(grant_wfid), 64'(7));
    end
    cyc(1, 0, 0);
    chk("p4_out7", 64'(outstanding[7]), 64'(1));
    chk("p4_drop_gv", 64'(grant_valid), 64'(0));

    // Same-cycle ack and done; stray dones have no effect
    do_reset();
    fetch_ready = 40'(1) << 3;
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    fetch_ready = 40'(1) << 10;
    cyc(0, 0, 0);
    cyc(1, 1, 6'd3);
    chk("p5_out10", 64'(outstanding[10]), 64'(1));
    chk("p5_out3", 64'(outstanding[3]), 64'(0));
    fetch_ready = '0;
    cyc(0, 1, 6'd20);
    cyc(0, 1, 6'd45);
    chk("p5_stray", 64'(outstanding), 64'(40'(1) << 10));

    // Reset while offering
    do_reset();
    fetch_ready = (40'(1) << 1) | (40'(1) << 4);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    fetch_ready = '1;
    cyc(0, 0, 0);
    chk("p6_offer_gv", 64'(grant_valid), 64'(1));
    rst = 1'b1;
    cyc(0, 0, 0);
    chk("p6_rst_gv", 64'(grant_valid), 64'(0));
    chk("p6_rst_out", 64'(outstanding), 64'(0));
    rst = 1'b0;
    cyc(0, 0, 0);
    chk("p6_first_gv", 64'(grant_valid), 64'(1));
    chk("p6_first_wf", 64'(grant_wfid), 64'(0));

    // Random traffic, checked by the scoreboard
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      r = {$urandom(), $urandom()};
      case ($urandom_range(0, 3))
        0: fetch_ready = r[39:0];
        1: fetch_ready = r[39:0] & r[63:24];
        2: fetch_ready = 40'(1) << $urandom_range(0, NWF - 1);
        default: ;
      endcase
      dv = 0; dw = '0;
      if ($urandom_range(0, 1) == 0) begin
        cand.delete();
        for (int i = 0; i < NWF; i++) if (m_outs[i]) cand.push_back(i);
        dv = 1;
        if (cand.size() > 0 && $urandom_range(0, 4) != 0)
          dw = 6'(cand[$urandom_range(0, cand.size() - 1)]);
        else
          dw = 6'($urandom_range(0, 63));
      end
      cyc($urandom_range(0, 2) != 0, dv, dw);
    end
    rst = 1'b0;
    fetch_ready = '0;
    repeat (3) cyc(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
